// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency single-outstanding read/write port
// over a MEM_WORDS x 16 array, with stall back-pressure and reject pulses.
module imem_responder #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rd_word_q, rd_word_d;
    logic            is_read_q, is_read_d;
    logic [DW-1:0]   data_out_q, data_out_d;
    logic            done_q, done_d;
    logic            stall_q, stall_d;
    logic            err_q, err_d;
    logic [DW-1:0]   mem_q [MEM_WORDS];

    logic            addr_ok;
    logic            accept;
    logic            mem_we;
    logic [AW-1:0]   mem_idx;

    // Next-state, acceptance and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_word_d  = rd_word_q;
        is_read_d  = is_read_q;
        mem_we     = 1'b0;
        mem_idx    = AW'(addr[8:1]);
        addr_ok    = (addr[0] == 1'b0) && (addr[15:9] == 7'd0);
        accept     = !stall_q && (rd ^ wr) && addr_ok;
        err_d      = !stall_q && (rd | wr) && !((rd ^ wr) && addr_ok);

        if (accept) begin
            state_d   = BUSY;
            cnt_d     = CW'(LATENCY - 1);
            is_read_d = rd;
            rd_word_d = rd ? mem_q[mem_idx] : '0;
            mem_we    = wr;
        end else if (state_q == BUSY && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // Counter at zero in BUSY marks the done cycle; nonzero means stalled
        stall_d    = (state_d == BUSY) && (cnt_d != '0);
        done_d     = (state_d == BUSY) && (cnt_d == '0);
        data_out_d = (done_d && is_read_d) ? rd_word_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_word_q  <= '0;
            is_read_q  <= 1'b0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            stall_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_word_q  <= rd_word_d;
            is_read_q  <= is_read_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    // Storage array; reset wipes every word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
    assign stall    = stall_q;
    assign err      = err_q;

endmodule
